conv_pass_sched: RTL



---
 rtl/conv_pass_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_pass_sched.sv
// Layer scheduler for the 3x3 PE-array convolution datapath.
// Runs CO x CI passes (co outer, ci inner). Each pass loads one kernel word,
// pulses start_conv, streams one IFM_SIZE x IFM_SIZE channel and then waits
// for end_conv, with a timeout that aborts the layer and raises a sticky err.
module conv_pass_sched #(
  parameter int IFM_SIZE    = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int CI          = 3,
  parameter int CO          = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  wgt_valid,
  output logic                                  wgt_ready,
  output logic                                  set_wgt,
  input  logic                                  ifm_valid,
  output logic                                  ifm_ready,
  output logic                                  set_ifm,
  output logic                                  start_conv,
  input  logic                                  end_conv,
  output logic                                  acc_en,
  output logic                                  last_ci,
  output logic [((CI > 1) ? $clog2(CI) : 1)-1:0] ci_idx,
  output logic [((CO > 1) ? $clog2(CO) : 1)-1:0] co_idx,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int CIW  = (CI > 1) ? $clog2(CI) : 1;
  localparam int COW  = (CO > 1) ? $clog2(CO) : 1;
  localparam int NPIX = IFM_SIZE * IFM_SIZE;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX + 1) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0]  PIX_LAST = PW'(NPIX - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CIW-1:0] CI_LAST  = CIW'(CI - 1);
  localparam logic [COW-1:0] CO_LAST  = COW'(CO - 1);

  // The kernel size only shapes the datapath; here it is just sanity-checked.
  if (KERNEL_SIZE < 1 || IFM_SIZE < 1 || CI < 1 || CO < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("conv_pass_sched: all size parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_WGT, S_START, S_STREAM, S_WAIT_END, S_NEXT, S_DONE
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_pix_cnt;
  logic [TW-1:0]  r_tmo_cnt;
  logic           r_end_flag;
  logic [CIW-1:0] r_ci;
  logic [COW-1:0] r_co;
  logic           r_acc_en;
  logic           r_last_ci;
  logic           r_wgt_ready;
  logic           r_ifm_ready;
  logic           r_start_conv;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic [CIW-1:0] w_ci_inc;

  assign w_ci_inc   = r_ci + CIW'(1);

  assign wgt_ready  = r_wgt_ready;
  assign set_wgt    = wgt_valid & r_wgt_ready;
  assign ifm_ready  = r_ifm_ready;
  assign set_ifm    = ifm_valid & r_ifm_ready;
  assign start_conv = r_start_conv;
  assign acc_en     = r_acc_en;
  assign last_ci    = r_last_ci;
  assign ci_idx     = r_ci;
  assign co_idx     = r_co;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

  // Pass sequencer: state, counters and all registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pix_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_end_flag   <= 1'b0;
      r_ci         <= '0;
      r_co         <= '0;
      r_acc_en     <= 1'b0;
      r_last_ci    <= 1'b0;
      r_wgt_ready  <= 1'b0;
      r_ifm_ready  <= 1'b0;
      r_start_conv <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_start_conv <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ci        <= '0;
            r_co        <= '0;
            r_acc_en    <= 1'b0;
            r_last_ci   <= (CI == 1);
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_wgt_ready <= 1'b1;
            r_state     <= S_LOAD_WGT;
          end
        end
        S_LOAD_WGT: begin
          if (wgt_valid) begin
            r_wgt_ready  <= 1'b0;
            r_start_conv <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_pix_cnt   <= '0;
          r_end_flag  <= 1'b0;
          r_ifm_ready <= 1'b1;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          // An early end_conv must not be lost while pixels are still flowing.
          if (end_conv) r_end_flag <= 1'b1;
          if (ifm_valid) begin
            r_pix_cnt <= r_pix_cnt + PW'(1);
            if (r_pix_cnt == PIX_LAST) begin
              r_ifm_ready <= 1'b0;
              r_tmo_cnt   <= '0;
              r_state     <= S_WAIT_END;
            end
          end
        end
        S_WAIT_END: begin
          if (end_conv || r_end_flag) begin
            r_state <= S_NEXT;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        S_NEXT: begin
          if (r_ci != CI_LAST) begin
            r_ci        <= w_ci_inc;
            r_acc_en    <= 1'b1;
            r_last_ci   <= (w_ci_inc == CI_LAST);
            r_wgt_ready <= 1'b1;
            r_state     <= S_LOAD_WGT;
          end else if (r_co != CO_LAST) begin
            r_ci        <= '0;
            r_co        <= r_co + COW'(1);
            r_acc_en    <= 1'b0;
            r_last_ci   <= (CI == 1);
            r_wgt_ready <= 1'b1;
            r_state     <= S_LOAD_WGT;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
